instr_fetch_unit: RTL and testbench

INSTR_FETCH_UNIT -- requirements
Module: instr_fetch_unit

---
 rtl/instr_fetch_unit.sv | 133 +++++++++++++
 tb/tb_instr_fetch_unit.sv | 278 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/instr_fetch_unit.sv
// Instruction fetch unit: a PC walks instruction memory from the start address
// to prog_end. Fetched {word, pc} pairs go into a 2-entry FIFO that a consumer
// drains with a valid/ready handshake. br_valid redirects the PC and flushes
// the FIFO.
module instr_fetch_unit #(
    parameter int          MEM_BYTES = 256,
    parameter logic [31:0] RESET_PC  = 32'h0
) (
    input  logic        clk,
    input  logic        reset_n,
    input  logic        fetch_en,
    input  logic [31:0] prog_end,
    output logic [31:0] A,
    input  logic [31:0] RD,
    input  logic        br_valid,
    input  logic [31:0] br_target,
    output logic [31:0] instr,
    output logic [31:0] instr_pc,
    output logic        instr_valid,
    input  logic        instr_ready,
    output logic        halted
);

    localparam logic [31:0] ADDR_MASK = 32'(MEM_BYTES - 1);
    localparam logic [31:0] PC_INIT   = RESET_PC & ADDR_MASK & ~32'd3;

    typedef enum logic [1:0] {IDLE, RUN, HALT} state_t;

    state_t      r_state;
    logic [31:0] r_pc;
    // Set when the PC wrapped past the top of memory onto prog_end
    // (prog_end == MEM_BYTES), where r_pc alone cannot show the end.
    logic        r_end;
    logic [1:0]  r_count;
    logic [31:0] r_word0, r_word1;   // entry 0 is the FIFO head
    logic [31:0] r_pc0,   r_pc1;

    logic [31:0] w_pc_inc;
    logic        w_at_end;
    logic        w_pop;
    logic        w_push;

    assign w_pc_inc = r_pc + 32'd4;
    assign w_at_end = r_end || (r_pc == prog_end);
    // A branch overrides both the consumer handshake and the fetch
    assign w_pop    = (r_count != 2'd0) && instr_ready && !br_valid;
    assign w_push   = (r_state == RUN) && fetch_en && !w_at_end && !br_valid &&
                      ((r_count != 2'd2) || w_pop);

    assign A           = r_pc;
    assign instr       = r_word0;
    assign instr_pc    = r_pc0;
    assign instr_valid = (r_count != 2'd0);
    assign halted      = (r_state == HALT);

    // Control state: a branch wins, then enable and end-of-program checks
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_state <= IDLE;
        end else if (br_valid) begin
            r_state <= fetch_en ? RUN : IDLE;
        end else begin
            case (r_state)
                IDLE:    if (fetch_en) r_state <= RUN;
                RUN: begin
                    if (!fetch_en)     r_state <= IDLE;
                    else if (w_at_end) r_state <= HALT;
                end
                HALT:    r_state <= HALT;
                default: r_state <= IDLE;
            endcase
        end
    end

    // PC: redirect on branch, otherwise advance with every fetched word
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_pc  <= PC_INIT;
            r_end <= 1'b0;
        end else if (br_valid) begin
            r_pc  <= br_target & ADDR_MASK & ~32'd3;
            r_end <= 1'b0;
        end else if (w_push) begin
            r_pc  <= w_pc_inc & ADDR_MASK;
            r_end <= (w_pc_inc == prog_end);
        end
    end

    // Shift-style FIFO: pops move entry 1 into the head, pushes fill the
    // first free slot after any pop at the same edge
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_count <= 2'd0;
            r_word0 <= '0;
            r_word1 <= '0;
            r_pc0   <= '0;
            r_pc1   <= '0;
        end else if (br_valid) begin
            r_count <= 2'd0;
        end else begin
            case ({w_push, w_pop})
                2'b01: begin
                    r_word0 <= r_word1;
                    r_pc0   <= r_pc1;
                    r_count <= r_count - 2'd1;
                end
                2'b10: begin
                    if (r_count == 2'd0) begin
                        r_word0 <= RD;
                        r_pc0   <= r_pc;
                    end else begin
                        r_word1 <= RD;
                        r_pc1   <= r_pc;
                    end
                    r_count <= r_count + 2'd1;
                end
                2'b11: begin
                    if (r_count == 2'd1) begin
                        r_word0 <= RD;
                        r_pc0   <= r_pc;
                    end else begin
                        r_word0 <= r_word1;
                        r_pc0   <= r_pc1;
                        r_word1 <= RD;
                        r_pc1   <= r_pc;
                    end
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_instr_fetch_unit.sv
// Scoreboard bench for instr_fetch_unit: each test queues the instructions it
// expects the consumer to receive, and a monitor pops/compares on every
// accepted handshake.
module tb_instr_fetch_unit;

    typedef struct packed {
        logic [31:0] word;
        logic [31:0] pc;
    } ent_t;

    logic        clk = 1'b0;
    logic        reset_n;
    logic        fetch_en;
    logic [31:0] prog_end;
    logic [31:0] A;
    logic [31:0] RD;
    logic        br_valid;
    logic [31:0] br_target;
    logic [31:0] instr;
    logic [31:0] instr_pc;
    logic        instr_valid;
    logic        instr_ready;
    logic        halted;

    int   n_checks = 0;
    int   n_fail   = 0;
    ent_t sb[$];

    instr_fetch_unit #(.MEM_BYTES(256), .RESET_PC(32'h0)) dut (
        .clk(clk), .reset_n(reset_n), .fetch_en(fetch_en), .prog_end(prog_end),
        .A(A), .RD(RD), .br_valid(br_valid), .br_target(br_target),
        .instr(instr), .instr_pc(instr_pc), .instr_valid(instr_valid),
        .instr_ready(instr_ready), .halted(halted)
    );

    always #5 clk = ~clk;

    function automatic logic [31:0] mem_word(input logic [31:0] a);
        logic [7:0] b;
        b = a[7:0];
        return {b + 8'd3, b + 8'd2, b + 8'd1, b};
    endfunction

    assign RD = mem_word(A);

    function automatic void push_exp(input logic [31:0] a);
        sb.push_back({mem_word(a), a});
    endfunction

    // Monitor: every accepted instruction must match the scoreboard head
    always @(negedge clk) begin
        if (reset_n && instr_valid && instr_ready && !br_valid) begin
            n_checks++;
            if (sb.size() == 0) begin
                n_fail++;
                $display("FAIL unexpected_instr: got %h @%h, none expected", instr, instr_pc);
            end else begin
                ent_t e;
                e = sb.pop_front();
                if (instr !== e.word || instr_pc !== e.pc) begin
                    n_fail++;
                    $display("FAIL instr_stream: got %h @%h, expected %h @%h",
                             instr, instr_pc, e.word, e.pc);
                end
            end
        end
    end

    task automatic cyc(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        reset_n     = 1'b0;
        fetch_en    = 1'b0;
        br_valid    = 1'b0;
        br_target   = '0;
        instr_ready = 1'b0;
        prog_end    = '0;
        sb.delete();
        cyc(2);
        reset_n = 1'b1;
    endtask

    task automatic wait_drain(input int max);
        for (int i = 0; i < max; i++) begin
            @(negedge clk);
            #1;
            if (sb.size() == 0 && !instr_valid) break;
        end
    endtask

    task automatic test_reset();
        reset_n = 1'b0; fetch_en = 1'b1; br_valid = 1'b0; br_target = '0;
        instr_ready = 1'b1; prog_end = 32'h10;
        #1;
        n_checks++;
        if (A !== 32'h0 || instr_valid !== 1'b0 || halted !== 1'b0 ||
            instr !== 32'h0 || instr_pc !== 32'h0) begin
            n_fail++;
            $display("FAIL reset_state: A=%h v=%b h=%b instr=%h pc=%h, expected all 0",
                     A, instr_valid, halted, instr, instr_pc);
        end
    endtask

    task automatic test_basic();
        do_reset();
        prog_end = 32'h10; fetch_en = 1'b1; instr_ready = 1'b1;
        for (int a = 0; a < 16; a += 4) push_exp(a);
        wait_drain(40);
        n_checks++;
        if (sb.size() != 0) begin
            n_fail++;
            $display("FAIL basic_drain: %0d left, expected 0", sb.size());
        end
        n_checks++;
        if (halted !== 1'b1 || instr_valid !== 1'b0 || A !== 32'h10) begin
            n_fail++;
            $display("FAIL basic_halt: h=%b v=%b A=%h, expected 1 0 00000010", halted, instr_valid, A);
        end
    endtask

    task automatic test_stall();
        do_reset();
        prog_end = 32'h40; fetch_en = 1'b1;
        cyc(8);
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            n_checks++;
            if (A !== 32'h8 || instr_valid !== 1'b1 || instr !== 32'h03020100 || instr_pc !== 32'h0) begin
                n_fail++;
                $display("FAIL stall_hold: A=%h v=%b %h @%h, expected 8 1 03020100 @0",
                         A, instr_valid, instr, instr_pc);
            end
        end
        for (int a = 0; a < 'h40; a += 4) push_exp(a);
        cyc(1);
        instr_ready = 1'b1;
        wait_drain(80);
        n_checks++;
        if (sb.size() != 0 || halted !== 1'b1) begin
            n_fail++;
            $display("FAIL stall_drain: %0d left h=%b, expected 0 left h=1", sb.size(), halted);
        end
    endtask

    task automatic test_branch();
        do_reset();
        prog_end = 32'h30; fetch_en = 1'b1;
        cyc(5);
        br_valid = 1'b1; br_target = 32'h23;
        cyc(1);
        br_valid = 1'b0;
        @(negedge clk);
        n_checks++;
        if (instr_valid !== 1'b0 || A !== 32'h20) begin
            n_fail++;
            $display("FAIL branch_flush: v=%b A=%h, expected 0 00000020", instr_valid, A);
        end
        for (int a = 'h20; a < 'h30; a += 4) push_exp(a);
        cyc(1);
        instr_ready = 1'b1;
        wait_drain(40);
        n_checks++;
        if (sb.size() != 0 || halted !== 1'b1) begin
            n_fail++;
            $display("FAIL branch_drain: %0d left h=%b, expected 0 left h=1", sb.size(), halted);
        end
    endtask

    task automatic test_wrap();
        do_reset();
        prog_end = 32'h100; fetch_en = 1'b1; instr_ready = 1'b1;
        br_valid = 1'b1; br_target = 32'hF8;
        push_exp(32'hF8);
        push_exp(32'hFC);
        cyc(1);
        br_valid = 1'b0;
        wait_drain(40);
        cyc(1);
        n_checks++;
        if (sb.size() != 0 || halted !== 1'b1 || instr_valid !== 1'b0 || A !== 32'h0) begin
            n_fail++;
            $display("FAIL wrap_halt: %0d left h=%b v=%b A=%h, expected 0 1 0 00000000",
                     sb.size(), halted, instr_valid, A);
        end
        br_valid = 1'b1; br_target = 32'h0; prog_end = 32'h8;
        push_exp(32'h0);
        push_exp(32'h4);
        cyc(1);
        br_valid = 1'b0;
        @(negedge clk);
        n_checks++;
        if (halted !== 1'b0) begin
            n_fail++;
            $display("FAIL halt_exit: h=%b, expected 0", halted);
        end
        wait_drain(40);
        n_checks++;
        if (sb.size() != 0) begin
            n_fail++;
            $display("FAIL halt_exit_drain: %0d left, expected 0", sb.size());
        end
    endtask

    task automatic test_reset_mid();
        do_reset();
        prog_end = 32'h40; fetch_en = 1'b1;
        cyc(5);
        @(negedge clk);
        #2 reset_n = 1'b0;
        #1;
        n_checks++;
        if (instr_valid !== 1'b0 || instr !== 32'h0 || instr_pc !== 32'h0 || A !== 32'h0 || halted !== 1'b0) begin
            n_fail++;
            $display("FAIL async_reset: v=%b instr=%h pc=%h A=%h h=%b, expected all 0",
                     instr_valid, instr, instr_pc, A, halted);
        end
        #1 reset_n = 1'b1;
        sb.delete();
        prog_end = 32'h8;
        push_exp(32'h0);
        push_exp(32'h4);
        instr_ready = 1'b1;
        wait_drain(40);
        n_checks++;
        if (sb.size() != 0 || halted !== 1'b1) begin
            n_fail++;
            $display("FAIL reset_resume: %0d left h=%b, expected 0 left h=1", sb.size(), halted);
        end
    endtask

    task automatic test_fetch_en();
        do_reset();
        prog_end = 32'h10; fetch_en = 1'b1;
        cyc(5);
        fetch_en = 1'b0;
        cyc(2);
        n_checks++;
        if (A !== 32'h8 || instr_valid !== 1'b1) begin
            n_fail++;
            $display("FAIL fetch_off_hold: A=%h v=%b, expected 00000008 1", A, instr_valid);
        end
        push_exp(32'h0);
        push_exp(32'h4);
        instr_ready = 1'b1;
        cyc(4);
        n_checks++;
        if (sb.size() != 0 || A !== 32'h8 || instr_valid !== 1'b0) begin
            n_fail++;
            $display("FAIL fetch_off_drain: %0d left A=%h v=%b, expected 0 00000008 0",
                     sb.size(), A, instr_valid);
        end
        push_exp(32'h8);
        push_exp(32'hC);
        fetch_en = 1'b1;
        wait_drain(40);
        n_checks++;
        if (sb.size() != 0 || halted !== 1'b1) begin
            n_fail++;
            $display("FAIL fetch_resume: %0d left h=%b, expected 0 left h=1", sb.size(), halted);
        end
    endtask

    initial begin
        test_reset();
        test_basic();
        test_stall();
        test_branch();
        test_wrap();
        test_reset_mid();
        test_fetch_en();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
